// File: rtl/acc_mem_pkg.sv
// rtl/acc_mem_pkg.sv - shared types and constants for the accumulator memory access unit
package acc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_PC  = 2'd0;
    localparam logic [1:0] SEL_IR  = 2'd1;
    localparam logic [1:0] SEL_RA  = 2'd2;
    localparam logic [1:0] SEL_ALU = 2'd3;

    localparam int IO_WINDOW_WORDS = 8;

endpackage

// File: rtl/acc_mem_ram.sv
// rtl/acc_mem_ram.sv - single-port word RAM, synchronous write, asynchronous read, never cleared
module acc_mem_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/acc_mem_unit.sv
// rtl/acc_mem_unit.sv - accumulator-machine memory access unit with wait states
// Memory-mapped IO window in the top 8 words is built only when ACC_MEM_IO_EN is defined.
module acc_mem_unit
    import acc_mem_pkg::*;
#(
    parameter int          DATA_WIDTH  = 16,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          NUM_IO      = 2,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] RA_ADDR     = 16'h07FE
) (
    input  logic                         CLK,
    input  logic                         Reset_n,
    input  logic                         req,
    input  logic                         we,
    input  logic [1:0]                   addr_sel,
    input  logic                         data_sel,
    input  logic                         ir_load,
    input  logic [DATA_WIDTH-1:0]        PC,
    input  logic [DATA_WIDTH-1:0]        IR,
    input  logic [DATA_WIDTH-1:0]        ACC,
    input  logic [DATA_WIDTH-1:0]        ALUOut,
    input  logic [NUM_IO*DATA_WIDTH-1:0] io_in,
    output logic                         ack,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        mdr_out,
    output logic [DATA_WIDTH-1:0]        ir_out,
    output logic [NUM_IO*DATA_WIDTH-1:0] io_out,
    output logic                         err
);

    localparam logic [2:0]            WAIT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [ADDR_WIDTH-1:0] RA_EFF    = RA_ADDR[ADDR_WIDTH-1:0];

    state_t                state, state_nx;
    logic [2:0]            wait_cnt;
    logic                  we_q;
    logic                  irl_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  accept;
    logic                  done_edge;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_ops;

    assign unused_ops = ^{IR, ALUOut};

    always_comb begin
        sel_addr = ALUOut[ADDR_WIDTH-1:0];
        case (addr_sel)
            SEL_PC:  sel_addr = PC[ADDR_WIDTH-1:0];
            SEL_IR:  sel_addr = IR[ADDR_WIDTH-1:0];
            SEL_RA:  sel_addr = RA_EFF;
            default: sel_addr = ALUOut[ADDR_WIDTH-1:0];
        endcase
    end

    assign accept = req && ((state == ST_IDLE) || (state == ST_DONE));

    // The cycle whose closing edge enters DONE: writes commit and read data is captured there.
    assign done_edge = ((state == ST_ACCESS) && (WAIT_STATES == 0)) ||
                       ((state == ST_WAIT) && (wait_cnt == WAIT_LAST));

    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                busy     = 1'b1;
                state_nx = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == WAIT_LAST) state_nx = ST_DONE;
            end
            ST_DONE: begin
                ack      = 1'b1;
                state_nx = req ? ST_ACCESS : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt <= 3'd0;
            we_q     <= 1'b0;
            irl_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mdr_q    <= '0;
            ir_q     <= '0;
        end else begin
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end else begin
                wait_cnt <= 3'd0;
            end
            if (accept) begin
                we_q    <= we;
                irl_q   <= ir_load;
                addr_q  <= sel_addr;
                wdata_q <= data_sel ? PC : ACC;
            end
            if (done_edge && !we_q) begin
                mdr_q <= rd_word;
                if (irl_q) ir_q <= rd_word;
            end
        end
    end

`ifdef ACC_MEM_IO_EN
    logic                         io_hit;
    logic                         io_ok;
    logic [2:0]                   io_idx;
    logic [DATA_WIDTH-1:0]        io_rd;
    logic [NUM_IO*DATA_WIDTH-1:0] io_q;
    logic                         err_q;

    assign io_hit = &addr_q[ADDR_WIDTH-1:3];
    assign io_idx = addr_q[2:0];
    assign io_ok  = io_hit && (32'(io_idx) < NUM_IO);

    always_comb begin
        io_rd = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (io_idx == 3'(i)) io_rd = io_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Unmapped IO indices read as zero and swallow writes.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            io_q  <= '0;
            err_q <= 1'b0;
        end else if (done_edge) begin
            err_q <= io_hit && !io_ok;
            if (we_q && io_ok) begin
                for (int i = 0; i < NUM_IO; i++) begin
                    if (io_idx == 3'(i)) io_q[i*DATA_WIDTH +: DATA_WIDTH] <= wdata_q;
                end
            end
        end
    end

    assign rd_word = io_hit ? (io_ok ? io_rd : '0) : ram_rdata;
    assign ram_we  = done_edge && we_q && !io_hit;
    assign io_out  = io_q;
    assign err     = ack && err_q;
`else
    logic unused_io;

    assign unused_io = ^io_in;
    assign rd_word   = ram_rdata;
    assign ram_we    = done_edge && we_q;
    assign io_out    = '0;
    assign err       = 1'b0;
`endif

    assign mdr_out = mdr_q;
    assign ir_out  = ir_q;

    acc_mem_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (CLK),
        .we   (ram_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_acc_mem_unit.sv
// tb/tb_acc_mem_unit.sv - directed plus random bench for acc_mem_unit, WAIT_STATES=1 and WAIT_STATES=0 side by side
module tb_acc_mem_unit;

    localparam int NIO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, data_sel, ir_load;
    logic [1:0]  addr_sel;
    logic [15:0] pc, ir, acc, aluout;
    logic [31:0] io_in;

    logic [1:0]  ack_v, busy_v, err_v;
    logic [15:0] mdr_v [2];
    logic [15:0] iro_v [2];
    logic [31:0] ioo_v [2];

    int checks = 0;
    int failures = 0;

    logic [15:0] mem_m [2][1024];
    bit          vld_m [2][1024];
    logic [15:0] mdr_m [2];
    logic [15:0] ir_m [2];
    logic [15:0] io_m [2][NIO];
    bit          mdr_known [2];
    bit          exp_err [2];
    int          lat [2];

    always #5 clk = ~clk;

    acc_mem_unit #(.WAIT_STATES(1)) dut_ws1 (
        .CLK(clk), .Reset_n(rst_n), .req(req), .we(we), .addr_sel(addr_sel),
        .data_sel(data_sel), .ir_load(ir_load), .PC(pc), .IR(ir), .ACC(acc),
        .ALUOut(aluout), .io_in(io_in), .ack(ack_v[0]), .busy(busy_v[0]),
        .mdr_out(mdr_v[0]), .ir_out(iro_v[0]), .io_out(ioo_v[0]), .err(err_v[0])
    );

    acc_mem_unit #(.WAIT_STATES(0)) dut_ws0 (
        .CLK(clk), .Reset_n(rst_n), .req(req), .we(we), .addr_sel(addr_sel),
        .data_sel(data_sel), .ir_load(ir_load), .PC(pc), .IR(ir), .ACC(acc),
        .ALUOut(aluout), .io_in(io_in), .ack(ack_v[1]), .busy(busy_v[1]),
        .mdr_out(mdr_v[1]), .ir_out(iro_v[1]), .io_out(ioo_v[1]), .err(err_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        mdr_m[d] = 16'h0;
        ir_m[d] = 16'h0;
        mdr_known[d] = 1'b1;
        for (int j = 0; j < NIO; j++) io_m[d][j] = 16'h0;
    endtask

    // Reference behaviour of one completed access on DUT d.
    task automatic model_apply(input int d, input bit w, input logic [9:0] a,
                               input logic [15:0] wd, input bit irl);
        bit          io_hit;
        int          idx;
        logic [15:0] rd;
        bit          known;
        io_hit = 1'b0;
`ifdef ACC_MEM_IO_EN
        io_hit = (a >= 10'h3F8);
`endif
        exp_err[d] = 1'b0;
        rd = 16'h0;
        known = 1'b1;
        if (io_hit) begin
            idx = int'(a) - 'h3F8;
            if (idx < NIO) begin
                if (w) io_m[d][idx] = wd;
                else rd = io_in[idx*16 +: 16];
            end else begin
                exp_err[d] = 1'b1;
            end
        end else if (w) begin
            mem_m[d][a] = wd;
            vld_m[d][a] = 1'b1;
        end else begin
            rd = mem_m[d][a];
            known = vld_m[d][a];
        end
        if (!w) begin
            mdr_m[d] = rd;
            mdr_known[d] = known;
            if (irl) ir_m[d] = rd;
        end
    endtask

    task automatic check_state(input int d);
        if (mdr_known[d]) chk($sformatf("mdr%0d", d), 32'(mdr_v[d]), 32'(mdr_m[d]));
        chk($sformatf("ir%0d", d), 32'(iro_v[d]), 32'(ir_m[d]));
        chk($sformatf("io_out%0d", d), ioo_v[d], {io_m[d][1], io_m[d][0]});
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_ack%0d", tag, d), 32'(ack_v[d]), 32'h0);
            chk($sformatf("%s_busy%0d", tag, d), 32'(busy_v[d]), 32'h0);
            chk($sformatf("%s_err%0d", tag, d), 32'(err_v[d]), 32'h0);
            chk($sformatf("%s_mdr%0d", tag, d), 32'(mdr_v[d]), 32'h0);
            chk($sformatf("%s_ir%0d", tag, d), 32'(iro_v[d]), 32'h0);
            chk($sformatf("%s_io%0d", tag, d), ioo_v[d], 32'h0);
        end
    endtask

    task automatic access(input bit w, input logic [1:0] sel, input bit ds, input bit irl,
                          input logic [15:0] p, input logic [15:0] i, input logic [15:0] ac,
                          input logic [15:0] al, input bit rst_mid);
        logic [15:0] src;
        bit          aborted [2];
        case (sel)
            2'd0:    src = p;
            2'd1:    src = i;
            2'd2:    src = 16'h07FE;
            default: src = al;
        endcase
        @(negedge clk);
        we = w; addr_sel = sel; data_sel = ds; ir_load = irl;
        pc = p; ir = i; acc = ac; aluout = al;
        io_in = $urandom;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        we = 1'($urandom); addr_sel = 2'($urandom); data_sel = 1'($urandom);
        ir_load = 1'($urandom); pc = 16'($urandom); ir = 16'($urandom);
        acc = 16'($urandom); aluout = 16'($urandom);
        for (int d = 0; d < 2; d++) begin
            aborted[d] = 1'b0;
            if (!(rst_mid && d == 0)) model_apply(d, w, src[9:0], ds ? p : ac, irl);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ack%0d_k%0d", d, k), 32'(ack_v[d]), 32'(!aborted[d] && k == lat[d]));
                chk($sformatf("busy%0d_k%0d", d, k), 32'(busy_v[d]), 32'(!aborted[d] && k < lat[d]));
                if (!aborted[d] && k == lat[d])
                    chk($sformatf("err%0d", d), 32'(err_v[d]), 32'(exp_err[d]));
            end
            if (rst_mid && k == 1) begin
                rst_n = 1'b0;
                #1;
                check_zero("midrst");
                rst_n = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    aborted[d] = 1'b1;
                    model_reset(d);
                end
            end
        end
        for (int d = 0; d < 2; d++) check_state(d);
    endtask

    task automatic rand_access(input bit w);
        logic [1:0]  sel;
        logic [15:0] vals [4];
        int          j;
        logic [9:0]  a10;
        sel = 2'($urandom);
        for (int n = 0; n < 4; n++) vals[n] = 16'($urandom);
        j = $urandom_range(0, 15);
        a10 = (j < 8) ? 10'(j) : 10'('h3F8 + j - 8);
        if (sel == 2'd0) vals[0] = {vals[0][15:10], a10};
        if (sel == 2'd1) vals[1] = {vals[1][15:10], a10};
        if (sel == 2'd3) vals[3] = {vals[3][15:10], a10};
        access(w, sel, 1'($urandom), 1'($urandom), vals[0], vals[1], vals[2], vals[3], 1'b0);
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 1;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr_sel = 2'd0; data_sel = 1'b0;
        ir_load = 1'b0; pc = 16'h0; ir = 16'h0; acc = 16'h0; aluout = 16'h0; io_in = 32'h0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            exp_err[d] = 1'b0;
            for (int a = 0; a < 1024; a++) vld_m[d][a] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Write ACC through ALUOut, read it back into IR.
        access(1'b1, 2'd3, 1'b0, 1'b0, 16'h5555, 16'h6666, 16'h1234, 16'h0010, 1'b0);
        access(1'b0, 2'd3, 1'b0, 1'b1, 16'h5555, 16'h6666, 16'h7777, 16'h0010, 1'b0);
        chk("rw_mdr", 32'(mdr_v[0]), 32'h1234);
        chk("rw_ir", 32'(iro_v[0]), 32'h1234);

        // req held high: WAIT_STATES=0 acks every 2 cycles, WAIT_STATES=1 every 3.
        @(negedge clk);
        we = 1'b0; addr_sel = 2'd3; aluout = 16'h0010; ir_load = 1'b0; req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack1_k%0d", k), 32'(ack_v[1]), 32'(k % 2 == 1));
            chk($sformatf("b2b_busy1_k%0d", k), 32'(busy_v[1]), 32'(k % 2 == 0));
            chk($sformatf("b2b_ack0_k%0d", k), 32'(ack_v[0]), 32'(k % 3 == 2));
            if (k == 7) req = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_apply(d, 1'b0, 10'h010, 16'h0, 1'b0);
            check_state(d);
        end

        // Pre-fill the random address pool, then mix reads and writes.
        for (int j = 0; j < 16; j++) begin
            access(1'b1, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'($urandom),
                   (j < 8) ? 16'(j) : 16'('h3F8 + j - 8), 1'b0);
        end
        for (int n = 0; n < 40; n++) rand_access(1'($urandom));

        // Return-address slot, upper address bits ignored on the read-back.
        access(1'b1, 2'd2, 1'b1, 1'b0, 16'h0042, 16'h0, 16'h0, 16'h0, 1'b0);
        access(1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'hFBFE, 1'b0);
`ifndef ACC_MEM_IO_EN
        chk("ra_slot", 32'(mdr_v[0]), 32'h0042);
`endif

        // IO index 1 write, then unmapped index 7.
        access(1'b1, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'hBEEF, 16'h03F9, 1'b0);
        access(1'b1, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'hDEAD, 16'h03FF, 1'b0);
`ifdef ACC_MEM_IO_EN
        chk("io_word1", 32'(ioo_v[0][31:16]), 32'hBEEF);
`else
        chk("io_const", ioo_v[0], 32'h0);
`endif

        // Reset during the WAIT of a write: WAIT_STATES=1 copy must keep the old word.
        access(1'b1, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'hA5A5, 16'h0005, 1'b1);
        access(1'b0, 2'd3, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0005, 1'b0);
        chk("abort_nowrite", 32'(mdr_v[0] !== 16'hA5A5), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_mem_unit.md
ACC_MEM_UNIT -- requirements
Module: acc_mem_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, RAM word address width (depth 2^ADDR_WIDTH).
REQ-003 SHALL have parameter NUM_IO, default 2, memory-mapped IO ports (legal 1..8).
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra cycles per access (legal 0..7).
REQ-005 SHALL have parameter RA_ADDR, default 16'h07FE, fixed return-address slot.
REQ-006 SHALL have port CLK, input, 1, rising-edge clock.
REQ-007 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req, input, 1, access request.
REQ-009 SHALL have port we, input, 1, 1=write, 0=read.
REQ-010 SHALL have port addr_sel, input, 2, address source: 0 PC, 1 IR, 2 RA_ADDR, 3 ALUOut.
REQ-011 SHALL have port data_sel, input, 1, write data source: 0 ACC, 1 PC.
REQ-012 SHALL have port ir_load, input, 1, load IR when the read completes.
REQ-013 SHALL have ports PC, IR, ACC, ALUOut, input, DATA_WIDTH each, datapath operands.
REQ-014 SHALL have port io_in, input, NUM_IO*DATA_WIDTH, IO input words.
REQ-015 SHALL have port ack, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port busy, output, 1, access in progress.
REQ-017 SHALL have port mdr_out, output, DATA_WIDTH, last read data.
REQ-018 SHALL have port ir_out, output, DATA_WIDTH, instruction register.
REQ-019 SHALL have port io_out, output, NUM_IO*DATA_WIDTH, IO output registers.
REQ-020 SHALL have port err, output, 1, unmapped-IO access flag, valid with ack.

Function
REQ-021 Effective address SHALL be selected source bits [ADDR_WIDTH-1:0]; upper bits ignored.
REQ-022 FSM states SHALL be IDLE, ACCESS, WAIT, DONE; busy=1 in ACCESS/WAIT.
REQ-023 IDLE with req=1 SHALL latch we, address, write data, ir_load and go to ACCESS.
REQ-024 ACCESS SHALL go to WAIT when WAIT_STATES>0, else DONE; WAIT SHALL last exactly WAIT_STATES cycles, then DONE.
REQ-025 Latency SHALL be: req sampled at edge n, ack high in the cycle after edge n+1+WAIT_STATES.
REQ-026 ack SHALL be high only in DONE, exactly one cycle per accepted request.
REQ-027 Writes SHALL commit on the edge entering DONE; reads SHALL update mdr_out on that edge and hold until the next read completes.
REQ-028 ir_out SHALL load the read word on that same edge only if latched ir_load=1 and we=0.
REQ-029 req in DONE SHALL be accepted (back-to-back, next ACCESS directly); req in ACCESS/WAIT SHALL be ignored, never queued.
REQ-030 Input changes after acceptance SHALL not affect the access in flight.
REQ-031 IO window SHALL be the top 8 words (address bits [ADDR_WIDTH-1:3] all ones); index = address[2:0].
REQ-032 IO write with index<NUM_IO SHALL update that io_out word; IO read SHALL return the io_in word sampled on the completion edge.
REQ-033 IO access with index>=NUM_IO SHALL drop writes, return 0 on reads, and assert err with ack.
REQ-034 Reads from a write-in-flight address SHALL not occur (single outstanding access).

Reset
REQ-035 Reset_n=0 SHALL immediately force IDLE, ack=0, busy=0, err=0, mdr_out=0, ir_out=0, io_out=0.
REQ-036 Reset mid-access SHALL abort it: no RAM write, no ack after release; RAM contents SHALL not be cleared.

Configuration
REQ-037 With macro ACC_MEM_IO_EN defined, the IO window (REQ-031..033) SHALL be present.
REQ-038 Without ACC_MEM_IO_EN, all addresses SHALL map to RAM, io_out SHALL be constant 0, err constant 0.

Structure
REQ-039 Package acc_mem_pkg SHALL hold the state enum, addr_sel encodings and IO window size constant.
REQ-040 RAM SHALL be sub-module acc_mem_ram (single-port, synchronous write, DATA_WIDTH x 2^ADDR_WIDTH).

Verification
REQ-041 Write ACC=16'h1234 via addr_sel=3 ALUOut=16'h0010, then read same with ir_load=1 -> mdr_out=ir_out=16'h1234, ack 3 cycles after each req (WAIT_STATES=1).
REQ-042 WAIT_STATES=0, req held high 4 accesses -> ack every 2 cycles, busy never high in DONE.
REQ-043 addr_sel=2 write PC=16'h0042 -> RAM[16'h07FE]=16'h0042 (RA_ADDR truncated to 10 bits = 16'h03FE).
REQ-044 Write 16'hBEEF to 16'h03F9 (IO index 1) -> io_out word1=16'hBEEF; write to 16'h03FF -> err=1, io_out unchanged.
REQ-045 Reset_n pulsed low during WAIT of a write -> no ack, target RAM word unchanged, all outputs 0.
